// File: rtl/aib_slave_link_fsm.sv
// AIB slave-side link bring-up sequencer: config handshake, MAC wake-up, DCC/DLL
// lock handshake with the master, link monitoring and bounded retry.
module aib_slave_link_fsm #(
    parameter int unsigned NUM_CHNL         = 24,
    parameter int unsigned CLK_FREQ_MHZ     = 100,
    parameter int unsigned WAKEUP_NS        = 1000,
    parameter int unsigned LOCK_TIMEOUT_CYC = 4096,
    parameter int unsigned MAX_RETRY        = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [NUM_CHNL-1:0]                chnl_mask,
    input  logic                               cfg_done,
    input  logic [NUM_CHNL-1:0]                ms_rx_dcc_dll_lock_req,
    input  logic [NUM_CHNL-1:0]                ms_tx_dcc_dll_lock_req,
    output logic                               cfg_start,
    output logic                               i_conf_done,
    output logic [NUM_CHNL-1:0]                ns_mac_rdy,
    output logic [NUM_CHNL-1:0]                ns_adapter_rstn,
    output logic [NUM_CHNL-1:0]                sl_rx_dcc_dll_lock_req,
    output logic [NUM_CHNL-1:0]                sl_tx_dcc_dll_lock_req,
    output logic [NUM_CHNL-1:0]                sl_rx_transfer_en,
    output logic [NUM_CHNL-1:0]                sl_tx_transfer_en,
    output logic                               link_up,
    output logic                               fail,
    output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt,
    output logic [2:0]                         state_o
);

    localparam int unsigned WAKEUP_RAW = (CLK_FREQ_MHZ * WAKEUP_NS) / 1000;
    localparam int unsigned WAKEUP_CYC = (WAKEUP_RAW > 1) ? WAKEUP_RAW : 1;
    localparam int unsigned CNT_MAX    = (WAKEUP_CYC > LOCK_TIMEOUT_CYC) ? WAKEUP_CYC : LOCK_TIMEOUT_CYC;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned RTY_W      = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONFIG   = 3'd1,
        ST_WAKEUP   = 3'd2,
        ST_WAIT_REQ = 3'd3,
        ST_RESPOND  = 3'd4,
        ST_LINK_UP  = 3'd5,
        ST_RETRY    = 3'd6,
        ST_FAIL     = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RTY_W-1:0]    rty_q, rty_d;
    logic [NUM_CHNL-1:0] mask_q, mask_d;
    logic                all_ok;

    logic                cfg_start_d, conf_done_d, link_up_d, fail_d;
    logic [NUM_CHNL-1:0] mac_rdy_d, adapter_rstn_d, lock_req_d, transfer_en_d;

    // A channel is satisfied when disabled or when the master requests both directions.
    assign all_ok = &(~mask_q | (ms_rx_dcc_dll_lock_req & ms_tx_dcc_dll_lock_req));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rty_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rty_q   <= rty_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        cnt_d          = cnt_q;
        rty_d          = rty_q;
        cfg_start_d    = 1'b0;
        conf_done_d    = 1'b0;
        link_up_d      = 1'b0;
        fail_d         = 1'b0;
        mac_rdy_d      = '0;
        adapter_rstn_d = '0;
        lock_req_d     = '0;
        transfer_en_d  = '0;

        // Teardown request overrides every other transition.
        if (state_q != ST_IDLE && !start) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && chnl_mask != '0) begin
                        state_d = ST_CONFIG;
                        mask_d  = chnl_mask;
                    end
                end
                ST_CONFIG: begin
                    if (cfg_done) state_d = ST_WAKEUP;
                end
                ST_WAKEUP: begin
                    if (cnt_q == CNT_W'(WAKEUP_CYC - 1)) state_d = ST_WAIT_REQ;
                end
                ST_WAIT_REQ: begin
                    if (all_ok) begin
                        state_d = ST_RESPOND;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
                        state_d = ST_RETRY;
                    end
                end
                ST_RESPOND: begin
                    state_d = ST_LINK_UP;
                end
                ST_LINK_UP: begin
                    if (!all_ok) state_d = ST_RETRY;
                end
                ST_RETRY: begin
                    if (cnt_q == CNT_W'(WAKEUP_CYC - 1)) begin
                        state_d = (rty_q == RTY_W'(MAX_RETRY)) ? ST_FAIL : ST_WAIT_REQ;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Delay counter restarts on every state change and saturates otherwise.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (state_d == ST_IDLE) begin
            rty_d = '0;
        end else if (state_d == ST_RETRY && state_q != ST_RETRY && rty_q != RTY_W'(MAX_RETRY)) begin
            rty_d = rty_q + RTY_W'(1);
        end

        // Output decode of the present state; registered below, so it lags one cycle.
        case (state_q)
            ST_CONFIG: begin
                cfg_start_d = 1'b1;
            end
            ST_WAKEUP, ST_RETRY: begin
                conf_done_d = 1'b1;
                mac_rdy_d   = mask_q;
            end
            ST_WAIT_REQ: begin
                conf_done_d    = 1'b1;
                mac_rdy_d      = mask_q;
                adapter_rstn_d = mask_q;
            end
            ST_RESPOND: begin
                conf_done_d    = 1'b1;
                mac_rdy_d      = mask_q;
                adapter_rstn_d = mask_q;
                lock_req_d     = mask_q;
            end
            ST_LINK_UP: begin
                conf_done_d    = 1'b1;
                mac_rdy_d      = mask_q;
                adapter_rstn_d = mask_q;
                lock_req_d     = mask_q;
                transfer_en_d  = mask_q;
                link_up_d      = 1'b1;
            end
            ST_FAIL: begin
                fail_d = 1'b1;
            end
            default: begin
                cfg_start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_start              <= 1'b0;
            i_conf_done            <= 1'b0;
            ns_mac_rdy             <= '0;
            ns_adapter_rstn        <= '0;
            sl_rx_dcc_dll_lock_req <= '0;
            sl_tx_dcc_dll_lock_req <= '0;
            sl_rx_transfer_en      <= '0;
            sl_tx_transfer_en      <= '0;
            link_up                <= 1'b0;
            fail                   <= 1'b0;
            retry_cnt              <= '0;
            state_o                <= 3'd0;
        end else begin
            cfg_start              <= cfg_start_d;
            i_conf_done            <= conf_done_d;
            ns_mac_rdy             <= mac_rdy_d;
            ns_adapter_rstn        <= adapter_rstn_d;
            sl_rx_dcc_dll_lock_req <= lock_req_d;
            sl_tx_dcc_dll_lock_req <= lock_req_d;
            sl_rx_transfer_en      <= transfer_en_d;
            sl_tx_transfer_en      <= transfer_en_d;
            link_up                <= link_up_d;
            fail                   <= fail_d;
            retry_cnt              <= rty_q;
            state_o                <= 3'(state_q);
        end
    end

endmodule

// File: tb/tb_aib_slave_link_fsm.sv
// Scoreboard bench for aib_slave_link_fsm: a phase/countdown reference model queues
// the expected output word every cycle; a negedge monitor pops and compares.
module tb_aib_slave_link_fsm;

    localparam int N  = 4;
    localparam int WK = 100;   // 100 MHz * 1000 ns
    localparam int LT = 50;
    localparam int MR = 2;

    localparam int P_IDLE = 0, P_CONFIG = 1, P_WAKEUP = 2, P_WAIT = 3;
    localparam int P_RESP = 4, P_LINK = 5, P_RETRY = 6, P_FAIL = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cfg_done = 1'b0;
    logic [N-1:0] chnl_mask = '0;
    logic [N-1:0] ms_rx = '0;
    logic [N-1:0] ms_tx = '0;

    logic         cfg_start, i_conf_done, link_up, fail;
    logic [N-1:0] ns_mac_rdy, ns_adapter_rstn;
    logic [N-1:0] sl_rx_lock, sl_tx_lock, sl_rx_xfer, sl_tx_xfer;
    logic [1:0]   retry_cnt;
    logic [2:0]   state_o;

    aib_slave_link_fsm #(
        .NUM_CHNL(N), .CLK_FREQ_MHZ(100), .WAKEUP_NS(1000),
        .LOCK_TIMEOUT_CYC(LT), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .chnl_mask(chnl_mask),
        .cfg_done(cfg_done),
        .ms_rx_dcc_dll_lock_req(ms_rx), .ms_tx_dcc_dll_lock_req(ms_tx),
        .cfg_start(cfg_start), .i_conf_done(i_conf_done),
        .ns_mac_rdy(ns_mac_rdy), .ns_adapter_rstn(ns_adapter_rstn),
        .sl_rx_dcc_dll_lock_req(sl_rx_lock), .sl_tx_dcc_dll_lock_req(sl_tx_lock),
        .sl_rx_transfer_en(sl_rx_xfer), .sl_tx_transfer_en(sl_tx_xfer),
        .link_up(link_up), .fail(fail), .retry_cnt(retry_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   st;
        logic [1:0]   rty;
        logic         cfg_start;
        logic         conf_done;
        logic         link;
        logic         fail;
        logic [N-1:0] mac;
        logic [N-1:0] rstn;
        logic [N-1:0] lrx;
        logic [N-1:0] ltx;
        logic [N-1:0] xrx;
        logic [N-1:0] xtx;
    } exp_t;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc_no = 0;

    // Reference model: phase, cycles left in a timed phase, retries used, latched mask.
    int           phase = P_IDLE;
    int           left = 0;
    int           retries = 0;
    logic [N-1:0] mmask = '0;
    logic         m_all_ok;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t outputs_for(int p, logic [N-1:0] m, int r);
        exp_t e;
        e           = '0;
        e.st        = 3'(p);
        e.rty       = 2'(r);
        e.cfg_start = (p == P_CONFIG);
        e.conf_done = (p >= P_WAKEUP && p <= P_RETRY);
        e.fail      = (p == P_FAIL);
        if (p >= P_WAKEUP && p <= P_RETRY) e.mac = m;
        if (p >= P_WAIT && p <= P_LINK) e.rstn = m;
        if (p == P_RESP || p == P_LINK) begin
            e.lrx = m;
            e.ltx = m;
        end
        if (p == P_LINK) begin
            e.xrx  = m;
            e.xtx  = m;
            e.link = 1'b1;
        end
        return e;
    endfunction

    function automatic void enter(int p);
        phase = p;
        if (p == P_WAKEUP) left = WK;
        else if (p == P_WAIT) left = LT;
        else if (p == P_RETRY) begin
            left = WK;
            if (retries < MR) retries++;
        end else if (p == P_IDLE) retries = 0;
    endfunction

    always @(posedge clk) begin
        cyc_no++;
        if (!rst_n) begin
            exp_q.push_back('0);
            phase   = P_IDLE;
            retries = 0;
            mmask   = '0;
        end else begin
            exp_q.push_back(outputs_for(phase, mmask, retries));
            m_all_ok = &(~mmask | (ms_rx & ms_tx));
            if (!start) begin
                if (phase != P_IDLE) enter(P_IDLE);
            end else begin
                case (phase)
                    P_IDLE:   if (chnl_mask != '0) begin mmask = chnl_mask; enter(P_CONFIG); end
                    P_CONFIG: if (cfg_done) enter(P_WAKEUP);
                    P_WAKEUP: begin left--; if (left == 0) enter(P_WAIT); end
                    P_WAIT: begin
                        if (m_all_ok) enter(P_RESP);
                        else begin left--; if (left == 0) enter(P_RETRY); end
                    end
                    P_RESP:   enter(P_LINK);
                    P_LINK:   if (!m_all_ok) enter(P_RETRY);
                    P_RETRY: begin
                        left--;
                        if (left == 0) enter(retries >= MR ? P_FAIL : P_WAIT);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor: every negedge the DUT presents a registered output word to compare.
    always @(negedge clk) begin
        exp_t e, a;
        a.st = state_o;       a.rty = retry_cnt;   a.cfg_start = cfg_start;
        a.conf_done = i_conf_done; a.link = link_up; a.fail = fail;
        a.mac = ns_mac_rdy;   a.rstn = ns_adapter_rstn;
        a.lrx = sl_rx_lock;   a.ltx = sl_tx_lock;  a.xrx = sl_rx_xfer; a.xtx = sl_tx_xfer;
        if (exp_q.size() == 0) begin
            e = '0;
            if (rst_n) chk("scoreboard_underflow", 32'(1), 32'(0));
        end else begin
            e = exp_q.pop_front();
        end
        if (!rst_n) e = '0;
        chk("state_o", 32'(a.st), 32'(e.st));
        chk("retry_cnt", 32'(a.rty), 32'(e.rty));
        chk("cfg_start", 32'(a.cfg_start), 32'(e.cfg_start));
        chk("i_conf_done", 32'(a.conf_done), 32'(e.conf_done));
        chk("link_up", 32'(a.link), 32'(e.link));
        chk("fail", 32'(a.fail), 32'(e.fail));
        chk("ns_mac_rdy", 32'(a.mac), 32'(e.mac));
        chk("ns_adapter_rstn", 32'(a.rstn), 32'(e.rstn));
        chk("sl_rx_lock_req", 32'(a.lrx), 32'(e.lrx));
        chk("sl_tx_lock_req", 32'(a.ltx), 32'(e.ltx));
        chk("sl_rx_transfer_en", 32'(a.xrx), 32'(e.xrx));
        chk("sl_tx_transfer_en", 32'(a.xtx), 32'(e.xtx));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(int p, int maxc, string name);
        int n = 0;
        while (int'(state_o) != p && n < maxc) begin
            cyc();
            n++;
        end
        chk(name, 32'(state_o), 32'(p));
    endtask

    initial begin
        int t0, t1, t2, drought;
        drought = 0;

        // Reset held with start=1 but an empty mask: must stay idle afterwards.
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) cyc();
        chk("empty_mask_stays_idle", 32'(state_o), 32'(P_IDLE));
        chk("empty_mask_no_cfg_start", 32'(cfg_start), 32'(0));

        // Nominal bring-up, cfg_done five cycles after cfg_start.
        chnl_mask = 4'hF; ms_rx = 4'hF; ms_tx = 4'hF;
        wait_state(P_CONFIG, 10, "reach_config");
        repeat (5) cyc();
        cfg_done = 1'b1; cyc(); cfg_done = 1'b0;
        for (int i = 0; i < 50 && ns_mac_rdy !== 4'hF; i++) cyc();
        t0 = cyc_no;
        for (int i = 0; i < 300 && ns_adapter_rstn !== 4'hF; i++) cyc();
        t1 = cyc_no;
        for (int i = 0; i < 50 && sl_rx_xfer !== 4'hF; i++) cyc();
        t2 = cyc_no;
        chk("mac_rdy_to_adapter_rstn", 32'(t1 - t0), 32'(WK));
        chk("adapter_rstn_to_transfer_en", 32'(t2 - t1), 32'(2));
        chk("nominal_link_up", 32'(link_up), 32'(1));

        // Mask changes are ignored once out of IDLE.
        chnl_mask = 4'h0; repeat (5) cyc();
        chk("mask_ignored_transfer_en", 32'(sl_tx_xfer), 32'(4'hF));

        // One-cycle loss of channel 2 TX request.
        ms_tx = 4'b1011; cyc(); ms_tx = 4'hF;
        wait_state(P_RETRY, 5, "link_loss_retry");
        chk("link_loss_retry_cnt", 32'(retry_cnt), 32'(1));
        wait_state(P_LINK, 300, "link_relock");

        // Partial mask with requests on channels 0 and 2 only.
        start = 1'b0; repeat (3) cyc();
        start = 1'b1; chnl_mask = 4'b0101; ms_rx = 4'b0101; ms_tx = 4'b0101;
        wait_state(P_CONFIG, 10, "partial_config");
        cfg_done = 1'b1; cyc(); cfg_done = 1'b0;
        wait_state(P_LINK, 300, "partial_link");
        chk("partial_adapter_rstn", 32'(ns_adapter_rstn), 32'(4'b0101));

        // No master requests: retries exhaust into FAIL.
        start = 1'b0; repeat (3) cyc();
        start = 1'b1; chnl_mask = 4'($urandom_range(1, 15)); ms_rx = '0; ms_tx = '0; cfg_done = 1'b1;
        wait_state(P_FAIL, 1000, "timeout_fail");
        cyc();
        chk("fail_flag", 32'(fail), 32'(1));
        chk("fail_retry_cnt", 32'(retry_cnt), 32'(MR));
        chk("fail_mac_rdy", 32'(ns_mac_rdy), 32'(0));

        // Teardown from WAKEUP.
        start = 1'b0; repeat (3) cyc();
        start = 1'b1; chnl_mask = 4'hF; ms_rx = 4'hF; ms_tx = 4'hF;
        wait_state(P_WAKEUP, 20, "reach_wakeup");
        repeat (3) cyc();
        start = 1'b0; cyc(); cyc();
        chk("teardown_state", 32'(state_o), 32'(P_IDLE));
        chk("teardown_mac_rdy", 32'(ns_mac_rdy), 32'(0));

        // Asynchronous reset in LINK_UP.
        start = 1'b1;
        wait_state(P_LINK, 300, "reach_link_for_reset");
        cyc();
        rst_n = 1'b0;
        #1;
        chk("async_reset_link_up", 32'(link_up), 32'(0));
        chk("async_reset_adapter_rstn", 32'(ns_adapter_rstn), 32'(0));
        chk("async_reset_state", 32'(state_o), 32'(P_IDLE));
        repeat (2) cyc();
        rst_n = 1'b1;
        wait_state(P_LINK, 300, "relink_after_reset");
        cfg_done = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (!start && ($urandom % 4 == 0)) start = 1'b1;
            else if ($urandom % 150 == 0) start = 1'b0;
            chnl_mask = ($urandom % 8 == 0) ? 4'h0 : 4'($urandom);
            cfg_done  = ($urandom % 6 == 0);
            if (drought == 0 && $urandom % 300 == 0) drought = int'($urandom_range(30, 160));
            if (drought > 0) begin
                drought--;
                ms_rx = 4'($urandom) & 4'($urandom);
                ms_tx = 4'($urandom) & 4'($urandom);
            end else begin
                ms_rx = ($urandom % 25 == 0) ? 4'($urandom) : 4'hF;
                ms_tx = ($urandom % 25 == 0) ? 4'($urandom) : 4'hF;
            end
            cyc();
        end

        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
